// File: rtl/riscv_ifu_pkg.sv
// riscv_ifu_pkg: shared widths, reset PC and FSM state encoding for the
// instruction fetch unit; is_aligned() tests a PC for word alignment.
package riscv_ifu_pkg;

  localparam int          IFU_XLEN     = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

  function automatic logic is_aligned(
    input logic [1:0] lo
  );
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/riscv_dff.sv
// riscv_dff: write-enabled register with async active-low reset.
// Ports: clk, rst_n, wen, d -> q (q loads RESET_VAL on reset).
module riscv_dff #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/riscv_ifu.sv
// riscv_ifu: single-outstanding fetch unit; memory req/rsp port in,
// held instruction (inst, inst_pc, inst_fault) to decode, redirect input.
module riscv_ifu
  import riscv_ifu_pkg::*;
#(
  parameter int                    DATA_WIDTH = IFU_XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  mem_rsp_ready,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic                  inst_fault,
  input  logic                  inst_ready
);

  ifu_state_e            state;
  logic                  kill;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_d;
  logic                  pc_wen;
  logic                  advance;
  logic                  req_fire;
  logic                  pc_ok;

  assign pc_ok    = is_aligned(pc[1:0]);
  assign advance  = (state == IFU_HOLD) && inst_ready;
  assign pc_wen   = advance | redirect_valid;
  assign pc_d     = redirect_valid ? redirect_pc
                                   : pc + DATA_WIDTH'(4);

  riscv_dff #(
    .WIDTH     (DATA_WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (pc_wen),
    .d     (pc_d),
    .q     (pc)
  );

  // A misaligned PC never reaches the bus.
  assign mem_req_valid = rst_n
                      && (state == IFU_REQ)
                      && pc_ok;
  assign mem_req_addr  = pc;
  assign mem_rsp_ready = (state == IFU_WAIT);
  assign req_fire      = mem_req_valid & mem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IFU_REQ;
      kill       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else begin
      unique case (state)
        IFU_REQ: begin
          if (redirect_valid) begin
            // Request already on the bus: its response is stale.
            if (req_fire) begin
              kill  <= 1'b1;
              state <= IFU_WAIT;
            end
          end else if (!pc_ok) begin
            state      <= IFU_HOLD;
            inst_valid <= 1'b1;
            inst_fault <= 1'b1;
            inst       <= '0;
            inst_pc    <= pc;
          end else if (req_fire) begin
            state <= IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          if (mem_rsp_valid) begin
            kill <= 1'b0;
            if (redirect_valid || kill) begin
              state <= IFU_REQ;
            end else begin
              state      <= IFU_HOLD;
              inst_valid <= 1'b1;
              inst_fault <= mem_rsp_err;
              inst       <= mem_rsp_err ? '0 : mem_rsp_data;
              inst_pc    <= pc;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        IFU_HOLD: begin
          if (redirect_valid || inst_ready) begin
            inst_valid <= 1'b0;
            state      <= IFU_REQ;
          end
        end
        default: begin
          state <= IFU_REQ;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  rsp_outside_wait: assert property (
    @(posedge clk) disable iff (!rst_n)
    mem_rsp_valid |-> (state == IFU_WAIT)
  );
`endif

endmodule

// File: tb/tb_riscv_ifu.sv
// tb_riscv_ifu: random memory/decode/redirect stimulus checked against a
// transaction-level fetch model, plus directed scenarios with literals.
module tb_riscv_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        mem_rsp_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready;

  riscv_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .mem_rsp_ready  (mem_rsp_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(
    input logic [31:0] a
  );
    return a[6:2] == 5'd1;
  endfunction

  function automatic logic exp_fault(
    input logic [31:0] p
  );
    return (p[1:0] != 2'b00) || mem_err(p);
  endfunction

  function automatic logic [31:0] exp_inst(
    input logic [31:0] p
  );
    return exp_fault(p) ? 32'h0 : mem_word(p);
  endfunction

  // memory model
  int          fix_lat = 0;
  int          rdy_pct = 100;
  logic        pend    = 1'b0;
  logic [31:0] paddr   = '0;
  int          pdelay  = 0;

  always begin
    @(negedge clk);
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (mem_rsp_valid && mem_rsp_ready) pend = 1'b0;
      else if (pend && pdelay > 0) pdelay--;
      if (mem_req_valid && mem_req_ready) begin
        pend   = 1'b1;
        paddr  = mem_req_addr;
        pdelay = (fix_lat >= 0) ? fix_lat
                                : int'($urandom_range(0, 3));
      end
    end
    @(posedge clk);
    #1;
    mem_rsp_valid = pend && (pdelay == 0);
    mem_rsp_data  = mem_rsp_valid ? mem_word(paddr) : $urandom;
    mem_rsp_err   = mem_rsp_valid && mem_err(paddr);
    mem_req_ready = int'($urandom_range(0, 99)) < rdy_pct;
  end

  // fetch model and per-cycle compare
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        f;
    int          cyc;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] req_q[$];
  logic [31:0] exp_pc = RST_PC;
  logic        chk_en = 1'b0;
  int          idle   = 0;
  int          cyc_n  = 0;

  always @(negedge clk) begin
    cyc_n++;
    if (!rst_n) begin
      exp_pc = RST_PC;
      idle   = 0;
    end else if (chk_en) begin
      if (mem_req_valid) begin
        chk("req_addr", mem_req_addr, exp_pc);
        chk("req_align", 32'(mem_req_addr[1:0]), 32'h0);
        chk("req_while_hold", 32'(inst_valid), 32'h0);
      end
      if (inst_valid) begin
        idle = 0;
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_fault", 32'(inst_fault), 32'(exp_fault(exp_pc)));
        chk("inst", inst, exp_inst(exp_pc));
      end else begin
        idle++;
        if (idle > 60) begin
          chk("watchdog_inst_valid", 32'(inst_valid), 32'h1);
          idle = 0;
        end
      end
      if (mem_req_valid && mem_req_ready)
        req_q.push_back(mem_req_addr);
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (inst_valid && inst_ready) begin
        acc_q.push_back('{inst_pc, inst, inst_fault, cyc_n});
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_iv(input string nm);
    for (int i = 0; i < 40 && !inst_valid; i++) cyc(1);
    chk(nm, 32'(inst_valid), 32'h1);
  endtask

  task automatic wait_wait(input string nm);
    for (int i = 0; i < 40 && !mem_rsp_ready; i++) cyc(1);
    chk(nm, 32'(mem_rsp_ready), 32'h1);
  endtask

  task automatic wait_acc(input int na, input string nm);
    for (int i = 0; i < 60 && acc_q.size() <= na; i++) cyc(1);
    chk(nm, 32'(acc_q.size() > na), 32'h1);
  endtask

  task automatic wait_req(input int nq, input string nm);
    for (int i = 0; i < 60 && req_q.size() <= nq; i++) cyc(1);
    chk(nm, 32'(req_q.size() > nq), 32'h1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_inst_valid"}, 32'(inst_valid), 32'h0);
    chk({nm, "_inst"}, inst, 32'h0);
    chk({nm, "_inst_pc"}, inst_pc, 32'h0);
    chk({nm, "_inst_fault"}, 32'(inst_fault), 32'h0);
    chk({nm, "_rsp_ready"}, 32'(mem_rsp_ready), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int na;
    int nq;
    int r;
    logic [31:0] held_pc;
    logic [31:0] base;
    logic        seen;

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    mem_rsp_err    = 1'b0;

    #22;
    chk_reset_outs("reset");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("first_req_valid", 32'(mem_req_valid), 32'h1);
    chk("first_req_addr", mem_req_addr, 32'h8000_0000);

    // zero-wait memory, decode always ready
    cyc(12);
    chk("ph1_count", 32'(acc_q.size() >= 3), 32'h1);
    if (acc_q.size() >= 3 && req_q.size() >= 3) begin
      chk("ph1_req0", req_q[0], 32'h8000_0000);
      chk("ph1_req1", req_q[1], 32'h8000_0004);
      chk("ph1_req2", req_q[2], 32'h8000_0008);
      chk("ph1_pc0", acc_q[0].pc, 32'h8000_0000);
      chk("ph1_inst0", acc_q[0].inst, 32'h9357_9BDF);
      chk("ph1_err_pc", acc_q[1].pc, 32'h8000_0004);
      chk("ph1_err_inst", acc_q[1].inst, 32'h0);
      chk("ph1_err_fault", 32'(acc_q[1].f), 32'h1);
      chk("ph1_pc2", acc_q[2].pc, 32'h8000_0008);
      chk("ph1_rate", 32'(acc_q[1].cyc - acc_q[0].cyc), 32'd3);
    end

    // decode stall
    inst_ready = 1'b0;
    wait_iv("stall_wait");
    na      = acc_q.size();
    held_pc = inst_pc;
    cyc(5);
    chk("stall_valid", 32'(inst_valid), 32'h1);
    chk("stall_pc", inst_pc, held_pc);
    chk("stall_no_acc", 32'(acc_q.size()), 32'(na));
    inst_ready = 1'b1;
    cyc(1);
    chk("stall_release", 32'(acc_q.size()), 32'(na + 1));

    // redirect in WAIT, response 3 cycles later
    fix_lat = 3;
    wait_wait("rw_wait");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    na = acc_q.size();
    nq = req_q.size();
    cyc(1);
    redirect_valid = 1'b0;
    wait_req(nq, "rw_req_seen");
    if (req_q.size() > nq)
      chk("rw_req_addr", req_q[nq], 32'h8000_0100);
    chk("rw_no_old_inst", 32'(acc_q.size()), 32'(na));

    // redirect in HOLD with inst_ready high
    fix_lat = 0;
    wait_iv("rh_wait");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    inst_ready     = 1'b1;
    na = acc_q.size();
    cyc(1);
    redirect_valid = 1'b0;
    chk("rh_dropped", 32'(acc_q.size()), 32'(na));
    wait_acc(na, "rh_acc");
    if (acc_q.size() > na)
      chk("rh_pc", acc_q[na].pc, 32'h8000_0200);

    // misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    cyc(1);
    redirect_valid = 1'b0;
    na = acc_q.size();
    nq = req_q.size();
    wait_acc(na, "mis_acc");
    if (acc_q.size() > na) begin
      chk("mis_pc", acc_q[na].pc, 32'h8000_0102);
      chk("mis_fault", 32'(acc_q[na].f), 32'h1);
      chk("mis_inst", acc_q[na].inst, 32'h0);
    end
    chk("mis_no_req", 32'(req_q.size()), 32'(nq));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    cyc(1);
    redirect_valid = 1'b0;

    // reset while waiting for a response
    fix_lat = 3;
    wait_wait("rst_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    chk("midrst_req_valid", 32'(mem_req_valid), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    nq = req_q.size();
    wait_req(nq, "midrst_req");
    if (req_q.size() > nq)
      chk("midrst_req_addr", req_q[nq], 32'h8000_0000);

    // randomized traffic
    fix_lat = -1;
    rdy_pct = 60;
    na = acc_q.size();
    for (int i = 0; i < 3000; i++) begin
      inst_ready = int'($urandom_range(0, 99)) < 70;
      r = int'($urandom_range(0, 99));
      redirect_valid = r < 5;
      base = 32'h8000_0000 | ($urandom & 32'h0000_03FC);
      seen = r < 1;
      redirect_pc = seen ? (base | 32'(2'($urandom_range(1, 3))))
                         : base;
      cyc(1);
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    cyc(20);
    chk("rand_progress", 32'(acc_q.size() - na > 150), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_ifu.md
Name: riscv_ifu

Overview:
Instruction fetch unit: owns the architectural fetch PC and issues one instruction read at a time over a valid/ready memory port. It presents the fetched instruction, with its PC, to decode over a valid/ready handshake. It sits directly upstream of the branch/next-PC unit, and accepts redirects (branch taken, jal, jalr) from that unit. Non-pipelined: at most one outstanding request.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction (matches `DATA_WIDTH in riscv_define.v)
RESET_PC, 32'h8000_0000, PC loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  single-cycle pulse: discard current fetch, restart at redirect_pc
redirect_pc  in  DATA_WIDTH  redirect target
mem_req_valid  out  1  fetch request valid
mem_req_addr  out  DATA_WIDTH  fetch address (= pc)
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  response valid
mem_rsp_data  in  DATA_WIDTH  instruction word
mem_rsp_err  in  1  access fault on this response
mem_rsp_ready  out  1  IFU accepts response
inst_valid  out  1  instruction to decode valid
inst  out  DATA_WIDTH  instruction word (0 on fault)
inst_pc  out  DATA_WIDTH  PC of inst
inst_fault  out  1  fetch fault (bus error or misaligned PC)
inst_ready  in  1  decode accepts instruction

Behaviour:
- Reset (async assert): pc=RESET_PC, state=REQ, kill=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0. mem_req_valid=1 is asserted combinationally from REQ once rst_n is high, so the request is visible in the first cycle after deassertion.
- States: REQ, WAIT, HOLD.
- REQ: mem_req_valid=1, mem_req_addr=pc. If pc[1:0]!=0, no request is issued (mem_req_valid=0); the unit goes to HOLD with inst_fault=1, inst=0, inst_pc=pc. On mem_req_ready it goes to WAIT.
- WAIT: mem_rsp_ready=1. On mem_rsp_valid with kill=0: latch inst=mem_rsp_data (0 if err), inst_fault=mem_rsp_err, inst_pc=pc, then go to HOLD. On mem_rsp_valid with kill=1: discard the response, clear kill, go to REQ.
- HOLD: inst_valid=1, and inst/inst_pc/inst_fault are stable until accepted. On inst_ready: pc<=pc+4 (mod 2^32, wraps silently), inst_valid<=0, go to REQ. A faulted instruction also advances on acceptance; trap handling belongs downstream.
- Redirect, in priority over the normal transition in the same cycle:
  - REQ without mem_req_ready: pc<=redirect_pc, stay in REQ. The address changes next cycle; the memory port tolerates this.
  - REQ with mem_req_ready: pc<=redirect_pc, kill<=1, go to WAIT.
  - WAIT: pc<=redirect_pc, kill<=1. If mem_rsp_valid arrives in the same cycle, discard it and go to REQ with kill=0.
  - HOLD: pc<=redirect_pc, inst_valid<=0 (the held instruction is dropped even if inst_ready=1), go to REQ.
- Latency: request-to-inst_valid is 1 cycle after mem_rsp_valid. Zero-wait memory gives one instruction per 3 cycles (REQ, WAIT, HOLD).
- mem_rsp_valid outside WAIT is a protocol violation: ignored, and flagged by an assertion.
- Reset mid-operation: all state returns to reset values; an outstanding response after reset is the memory's responsibility, since the memory shares rst_n.

Decomposition:
- riscv_define.v: `DATA_WIDTH, `RESET_PC, and the IFU state encodings (`IFU_REQ=2'd0, `IFU_WAIT=2'd1, `IFU_HOLD=2'd2).
- Sub-module: the pc register is a riscv_dff instance (WIDTH=DATA_WIDTH, RESET_VAL=RESET_PC, wen = advance | redirect).
- The FSM, kill flag and output register live in riscv_ifu.

Test Plan:
- Reset release with zero-wait memory, inst_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008; inst_valid once per 3 cycles with matching inst_pc.
- Decode stall: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, no new mem_req_valid; pc advances only after inst_ready=1.
- Redirect to 0x80000100 while in WAIT, response arrives 3 cycles later -> response discarded, next request addr=0x80000100, no inst_valid for the old PC.
- Redirect during HOLD with inst_ready=1 same cycle -> held instruction dropped, next request at the redirect target.
- Redirect to 0x80000102 -> no memory request; inst_valid=1, inst_fault=1, inst=0, inst_pc=0x80000102.
- mem_rsp_err=1 for 0x80000004 -> inst_fault=1, inst=0; after acceptance fetch continues at 0x80000008. Assert rst_n low mid-WAIT -> outputs return to reset values immediately.
